// File: rtl/wbmc_pkg.sv
// wbmc_pkg: shared definitions for the wb_multi_counter block.
//   - per-channel register byte offsets (channel stride 0x10)
//   - CTRL / STATUS bit indices
//   - global register base and offsets, PRESCALE width
//   - apply_sel(): byte-lane merge used for partial writes
package wbmc_pkg;

    localparam int unsigned CHAN_STRIDE = 16;

    // Byte offsets within a channel window
    localparam logic [3:0] REG_COUNT_OFF   = 4'h0;
    localparam logic [3:0] REG_COMPARE_OFF = 4'h4;
    localparam logic [3:0] REG_CTRL_OFF    = 4'h8;
    localparam logic [3:0] REG_STATUS_OFF  = 4'hC;

    // CTRL bits
    localparam int unsigned CTRL_EN          = 0;
    localparam int unsigned CTRL_DOWN        = 1;
    localparam int unsigned CTRL_AUTO_RELOAD = 2;
    localparam int unsigned CTRL_IRQ_EN      = 3;
    localparam int unsigned CTRL_W           = 4;

    // STATUS bits
    localparam int unsigned STATUS_MATCH = 0;

    // Global registers
    localparam logic [8:0] GLOBAL_BASE  = 9'h100;
    localparam logic [8:0] IRQ_PEND_OFF = 9'h100;
    localparam logic [8:0] PRESCALE_OFF = 9'h104;
    localparam int unsigned PRESCALE_W  = 16;

    // Replace the bytes of old_val selected by sel with those of wdata
    function automatic logic [31:0] apply_sel(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                res[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/wbmc_channel.sv
// wbmc_channel: one counter channel (COUNT, COMPARE, CTRL, sticky MATCH).
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   tick_i              shared count enable pulse
//   wr_*_i              single-cycle register write strobes from the bus decoder
//   wdata_i, sel_i      write data and byte lane enables
//   count_o, compare_o, ctrl_o, match_o   current register state
module wbmc_channel
    import wbmc_pkg::*;
#(
    parameter int unsigned BITS = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              tick_i,
    input  logic              wr_count_i,
    input  logic              wr_compare_i,
    input  logic              wr_ctrl_i,
    input  logic              wr_status_i,
    input  logic [31:0]       wdata_i,
    input  logic [3:0]        sel_i,
    output logic [BITS-1:0]   count_o,
    output logic [BITS-1:0]   compare_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic              match_o
);

    logic [BITS-1:0]   count_q, count_d, compare_q, compare_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              match_q, match_d;
    logic              run, set_match;
    logic [31:0]       count_ext, compare_ext, count_wr, compare_wr;

    always_comb begin
        count_ext                = '0;
        count_ext[BITS-1:0]      = count_q;
        compare_ext              = '0;
        compare_ext[BITS-1:0]    = compare_q;
        count_wr                 = apply_sel(count_ext, wdata_i, sel_i);
        compare_wr               = apply_sel(compare_ext, wdata_i, sel_i);

        count_d   = count_q;
        compare_d = compare_q;
        ctrl_d    = ctrl_q;
        match_d   = match_q;
        set_match = 1'b0;

        // A bus write to COUNT or CTRL supersedes this cycle's tick
        run = tick_i & ctrl_q[CTRL_EN] & ~wr_count_i & ~wr_ctrl_i;

        if (run) begin
            if (!ctrl_q[CTRL_DOWN]) begin
                if (count_q == compare_q) begin
                    set_match = 1'b1;
                    if (ctrl_q[CTRL_AUTO_RELOAD]) count_d = '0;
                    else                          ctrl_d[CTRL_EN] = 1'b0;
                end else begin
                    count_d = count_q + BITS'(1);
                end
            end else begin
                if (count_q == '0) begin
                    set_match = 1'b1;
                    if (ctrl_q[CTRL_AUTO_RELOAD]) count_d = compare_q;
                    else                          ctrl_d[CTRL_EN] = 1'b0;
                end else begin
                    count_d = count_q - BITS'(1);
                end
            end
        end

        if (wr_count_i)   count_d   = count_wr[BITS-1:0];
        if (wr_compare_i) compare_d = compare_wr[BITS-1:0];
        if (wr_ctrl_i)    ctrl_d    = wdata_i[CTRL_W-1:0];

        // Clear first so a simultaneous new match keeps the flag set
        if (wr_status_i && wdata_i[STATUS_MATCH]) match_d = 1'b0;
        if (set_match)                            match_d = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q   <= '0;
            compare_q <= '0;
            ctrl_q    <= '0;
            match_q   <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            ctrl_q    <= ctrl_d;
            match_q   <= match_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign ctrl_o    = ctrl_q;
    assign match_o   = match_q;

endmodule

// File: rtl/wb_multi_counter.sv
// wb_multi_counter: NCH independent up/down counters behind a Wishbone classic slave.
// Optional macro WBMC_PRESCALER_EN adds a shared 16-bit prescaler (PRESCALE at 0x104);
// without it every clock is a tick and PRESCALE reads 0.
// Ports:
//   wb_clk_i, wb_rst_i          clock, asynchronous active-high reset
//   wbs_cyc_i/stb_i/we_i        Wishbone cycle, strobe, write enable
//   wbs_sel_i, wbs_adr_i, wbs_dat_i   byte enables, byte address, write data
//   wbs_ack_o, wbs_dat_o        single-cycle acknowledge, registered read data
//   irq                         OR of enabled channel matches
//   count_o                     live counts, channel 0 in the LSBs
module wb_multi_counter
    import wbmc_pkg::*;
#(
    parameter int unsigned NCH  = 4,
    parameter int unsigned BITS = 32
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic [31:0]         wbs_dat_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    output logic                irq,
    output logic [NCH*BITS-1:0] count_o
);

    logic              ack_q;
    logic [31:0]       dat_q, rdata;
    logic              access, wr, is_global, tick;
    logic [8:0]        reg_addr;
    logic [3:0]        chan;
    logic [3:0]        chan_off;
    logic [NCH-1:0]    irq_pend;

    logic [BITS-1:0]   cnt [NCH];
    logic [BITS-1:0]   cmp [NCH];
    logic [CTRL_W-1:0] ctrl [NCH];
    logic [NCH-1:0]    match;

    logic unused_adr;
    assign unused_adr = ^{wbs_adr_i[31:9], wbs_adr_i[1:0]};

    // Accept a strobe only while ack is low so each access acks exactly once
    assign access    = wbs_cyc_i & wbs_stb_i & ~ack_q;
    assign wr        = access & wbs_we_i;
    assign reg_addr  = {wbs_adr_i[8:2], 2'b00};
    assign is_global = wbs_adr_i[8];
    assign chan      = wbs_adr_i[7:4];
    assign chan_off  = {wbs_adr_i[3:2], 2'b00};

`ifdef WBMC_PRESCALER_EN
    logic [PRESCALE_W-1:0] prescale_q, prescale_d, pcnt_q;
    logic                  wr_prescale;

    assign wr_prescale = wr & (reg_addr == PRESCALE_OFF);
    assign tick        = (pcnt_q == prescale_q);

    always_comb begin
        prescale_d = prescale_q;
        if (wbs_sel_i[0]) prescale_d[7:0]  = wbs_dat_i[7:0];
        if (wbs_sel_i[1]) prescale_d[15:8] = wbs_dat_i[15:8];
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            prescale_q <= '0;
            pcnt_q     <= '0;
        end else if (wr_prescale) begin
            prescale_q <= prescale_d;
            pcnt_q     <= '0;
        end else if (tick) begin
            pcnt_q     <= '0;
        end else begin
            pcnt_q     <= pcnt_q + 16'd1;
        end
    end
`else
    assign tick = 1'b1;
`endif

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        logic hit;
        assign hit = wr & ~is_global & (chan == 4'(c));

        wbmc_channel #(
            .BITS (BITS)
        ) u_chan (
            .clk_i        (wb_clk_i),
            .rst_i        (wb_rst_i),
            .tick_i       (tick),
            .wr_count_i   (hit & (chan_off == REG_COUNT_OFF)),
            .wr_compare_i (hit & (chan_off == REG_COMPARE_OFF)),
            .wr_ctrl_i    (hit & (chan_off == REG_CTRL_OFF)),
            .wr_status_i  (hit & (chan_off == REG_STATUS_OFF)),
            .wdata_i      (wbs_dat_i),
            .sel_i        (wbs_sel_i),
            .count_o      (cnt[c]),
            .compare_o    (cmp[c]),
            .ctrl_o       (ctrl[c]),
            .match_o      (match[c])
        );

        assign irq_pend[c]              = match[c] & ctrl[c][CTRL_IRQ_EN];
        assign count_o[c*BITS +: BITS] = cnt[c];
    end

    assign irq = |irq_pend;

    always_comb begin
        rdata = '0;
        if (is_global) begin
            if (reg_addr == IRQ_PEND_OFF) begin
                rdata[NCH-1:0] = irq_pend;
            end
`ifdef WBMC_PRESCALER_EN
            else if (reg_addr == PRESCALE_OFF) begin
                rdata[PRESCALE_W-1:0] = prescale_q;
            end
`endif
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (chan == 4'(c)) begin
                    case (chan_off)
                        REG_COUNT_OFF:   rdata[BITS-1:0]   = cnt[c];
                        REG_COMPARE_OFF: rdata[BITS-1:0]   = cmp[c];
                        REG_CTRL_OFF:    rdata[CTRL_W-1:0] = ctrl[c];
                        REG_STATUS_OFF:  rdata[STATUS_MATCH] = match[c];
                        default:         rdata = '0;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= access;
            if (access) dat_q <= rdata;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;

endmodule

// File: doc/wb_multi_counter.md
WB_MULTI_COUNTER -- requirements
Module: wb_multi_counter

Interface
REQ-001 Parameter NCH, default 4, number of independent counter channels (1..8).
REQ-002 Parameter BITS, default 32, counter/compare width per channel (8..32).
REQ-003 wb_clk_i  input  1  single clock; all state on its rising edge.
REQ-004 wb_rst_i  input  1  reset, asynchronous assert, active-high.
REQ-005 wbs_cyc_i, wbs_stb_i, wbs_we_i  input  1 each  Wishbone classic slave cycle, strobe, write enable.
REQ-006 wbs_sel_i  input  4  byte lane enables for writes.
REQ-007 wbs_adr_i, wbs_dat_i  input  32 each  byte address and write data.
REQ-008 wbs_ack_o  output  1 / wbs_dat_o  output  32  acknowledge and registered read data.
REQ-009 irq  output  1  level interrupt, OR of enabled channel matches.
REQ-010 count_o  output  NCH*BITS  live counter values, channel 0 in LSBs.

Function
REQ-011 Access is valid when wbs_cyc_i && wbs_stb_i; the block SHALL assert wbs_ack_o for exactly one cycle, the cycle after valid is sampled with ack low, and SHALL update registers/wbs_dat_o on that same edge.
REQ-012 Register map (byte offset): channel c at c*0x10 -- +0x0 COUNT RW, +0x4 COMPARE RW, +0x8 CTRL RW, +0xC STATUS; global 0x100 IRQ_PEND RO, 0x104 PRESCALE; decode on wbs_adr_i[8:2].
REQ-013 COUNT and COMPARE writes SHALL honour wbs_sel_i per byte; bytes above BITS ignored and read as 0.
REQ-014 CTRL bits: [0] EN, [1] DOWN, [2] AUTO_RELOAD, [3] IRQ_EN; other bits read 0.
REQ-015 STATUS[0] MATCH is sticky, cleared by writing 1 (W1C); IRQ_PEND[c] = MATCH[c] & IRQ_EN[c].
REQ-016 Unmapped or out-of-range-channel addresses SHALL ack, read 0, ignore writes.
REQ-017 Up mode (DOWN=0), on tick with EN=1: count==COMPARE sets MATCH and loads 0 if AUTO_RELOAD, else clears EN and holds count; otherwise count+1 modulo 2^BITS.
REQ-018 Down mode (DOWN=1), on tick with EN=1: count==0 sets MATCH and loads COMPARE if AUTO_RELOAD, else clears EN and holds 0; otherwise count-1.
REQ-019 Bus write to COUNT or CTRL in the same cycle as a tick SHALL win over the counter update for that channel.
REQ-020 A new MATCH set in the same cycle as a W1C clear SHALL leave MATCH=1.
REQ-021 irq SHALL be the OR of IRQ_PEND, derived combinationally from registered state (one-cycle delay from match edge).

Reset
REQ-022 While wb_rst_i is high: all COUNT, COMPARE, CTRL, MATCH, PRESCALE, prescaler counter, wbs_ack_o, wbs_dat_o, irq SHALL be 0; a transaction in flight is dropped without ack.

Configuration
REQ-023 Macro WBMC_PRESCALER_EN defined: PRESCALE is a 16-bit RW register and a shared tick pulses once every PRESCALE+1 clocks (PRESCALE=0 -> every clock); writing PRESCALE restarts the prescaler counter.
REQ-024 WBMC_PRESCALER_EN undefined: tick is constant 1, PRESCALE reads 0 and ignores writes, no prescaler flops present.

Structure
REQ-025 Package wbmc_pkg SHALL hold register offsets, CTRL/STATUS bit indices, global base 0x100 and PRESCALE width.
REQ-026 Sub-module wbmc_channel SHALL implement one channel's COUNT/COMPARE/CTRL/MATCH and be instantiated NCH times via generate; bus decode, ack, read mux, prescaler live in the top.

Verification
REQ-027 Write COMPARE0=5, CTRL0=0x5 (EN, AUTO_RELOAD) -> count_o[0] cycles 0..5,0; MATCH0 set on the wrap; irq stays 0.
REQ-028 CTRL1=0xB (EN, DOWN, IRQ_EN), COUNT1=3 -> counts 3,2,1,0, MATCH1 set, EN1 cleared, irq=1; write STATUS1=1 -> irq=0 next cycle.
REQ-029 Up mode one-shot COMPARE=0xFFFFFFFF near terminal, COUNT=0xFFFFFFFE -> stops at 0xFFFFFFFF with MATCH; with AUTO_RELOAD and COMPARE=0x10, COUNT=0xFFFFFFFF -> wraps to 0 without MATCH.
REQ-030 Write COUNT0 with wbs_sel_i=0x2, data 0x0000AB00 while running -> only byte1 becomes 0xAB, running continues from written value; ack exactly one cycle.
REQ-031 Assert wb_rst_i asynchronously mid-transaction with channels running -> all outputs 0 immediately, no ack; read of 0x1F0 after reset -> 0 with ack.
REQ-032 With WBMC_PRESCALER_EN, PRESCALE=3 -> channel increments once per 4 clocks; without macro PRESCALE reads 0.
